ram_bist_ctrl: RTL and testbench

Sequential fill-and-verify controller that sits directly upstream of the team's 256x8 single-port RAM and drives its address, data, write-enable and chip-select pins. On a start pulse it writes the pattern `(addr + OFFSET) mod 2^WORD` to every word, then reads every word back and compares it against the same pattern. When the pass completes it reports done, pass/fail, the error count and the first failing address. It is the power-on self-test and bring-up stage for the RAM.

---
 rtl/ram_bist_pkg.sv | 24 ++
 rtl/ram_bist_ctrl.sv | 124 ++++++++++++
 tb/tb_ram_bist_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types and defaults for the RAM fill-and-verify controller.
package ram_bist_pkg;

  localparam int WORD   = 8;
  localparam int ADDR   = 8;
  localparam int MEMS   = 256;
  localparam int OFFSET = 10;

  typedef enum logic [2:0] {
    IDLE,
    WR_SET,
    WR_CLR,
    RD,
    DONE
  } state_t;

  // Test pattern for one word: address plus offset, truncated to the word width.
  function automatic logic [WORD-1:0] pat(input logic [ADDR-1:0] addr);
    logic [31:0] sum;
    sum = 32'(addr) + 32'(OFFSET);
    return sum[WORD-1:0];
  endfunction

endpackage

// File: rtl/ram_bist_ctrl.sv
// Power-on fill-and-verify controller for the 256x8 single-port RAM.
// Writes (addr + OFFSET) to every word with a high-then-low write pulse,
// then reads every word back, counting mismatches and noting the first one.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int WORD   = ram_bist_pkg::WORD,
  parameter int ADDR   = ram_bist_pkg::ADDR,
  parameter int MEMS   = ram_bist_pkg::MEMS,
  parameter int OFFSET = ram_bist_pkg::OFFSET
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ADDR:0]   err_cnt,
  output logic [ADDR-1:0] first_err_ad,
  output logic [ADDR-1:0] ram_ad,
  output logic [WORD-1:0] ram_di,
  output logic            ram_w,
  output logic            ram_cs,
  input  logic [WORD-1:0] ram_do
);

  state_t state;
  state_t state_nxt;

  logic [ADDR-1:0] ad_next;
  logic            ad_last;
  logic            mismatch;

  // Pattern computed with this instance's widths so parameter overrides stay consistent.
  function automatic logic [WORD-1:0] pattern(input logic [ADDR-1:0] a);
    logic [31:0] sum;
    sum = 32'(a) + 32'(OFFSET);
    return sum[WORD-1:0];
  endfunction

  assign ad_next  = ram_ad + ADDR'(1);
  assign ad_last  = (ram_ad == ADDR'(MEMS - 1));
  assign mismatch = (ram_do != pattern(ram_ad));
  assign pass     = done && (err_cnt == '0);

  // State register; reset parks the controller in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and RAM strobes; start only matters in IDLE or DONE.
  always_comb begin
    state_nxt = state;
    ram_w     = 1'b0;
    ram_cs    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = WR_SET;
      end
      WR_SET: begin
        ram_w     = 1'b1;
        ram_cs    = 1'b1;
        busy      = 1'b1;
        state_nxt = WR_CLR;
      end
      WR_CLR: begin
        busy      = 1'b1;
        state_nxt = ad_last ? RD : WR_SET;
      end
      RD: begin
        ram_cs    = 1'b1;
        busy      = 1'b1;
        state_nxt = ad_last ? DONE : RD;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = WR_SET;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address counter, write data and read-back comparator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_ad       <= '0;
      ram_di       <= '0;
      err_cnt      <= '0;
      first_err_ad <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ram_ad       <= '0;
            ram_di       <= pattern('0);
            err_cnt      <= '0;
            first_err_ad <= '0;
          end
        end
        WR_CLR: begin
          ram_ad <= ad_next;
          ram_di <= pattern(ad_next);
        end
        RD: begin
          if (mismatch) begin
            err_cnt <= err_cnt + {{ADDR{1'b0}}, 1'b1};
            if (err_cnt == '0) first_err_ad <= ram_ad;
          end
          ram_ad <= ad_next;
          ram_di <= pattern(ad_next);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl: behavioural RAM with stuck-at-1 fault
// injection, a cycle-index reference model, and directed plus random runs.
module tb_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] err_cnt;
  logic [7:0] first_err_ad;
  logic [7:0] ram_ad;
  logic [7:0] ram_di;
  logic       ram_w;
  logic       ram_cs;
  logic [7:0] ram_do;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem    [256];
  logic [7:0] stuck1 [256];

  // Reference model: phase 0 idle, 1 running (mK = cycle index of the run), 2 done
  int mPhase = 0;
  int mK     = 0;
  int mErr   = 0;
  int mFirst = 0;

  ram_bist_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_cnt      (err_cnt),
    .first_err_ad (first_err_ad),
    .ram_ad       (ram_ad),
    .ram_di       (ram_di),
    .ram_w        (ram_w),
    .ram_cs       (ram_cs),
    .ram_do       (ram_do)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: combinational read with optional stuck-at-1 bits
  assign ram_do = mem[ram_ad] | stuck1[ram_ad];

  always @(posedge clk) begin
    if (ram_w && ram_cs) mem[ram_ad] <= ram_di;
  end

  function automatic logic [7:0] tbPat(input int a);
    return 8'((a + 10) % 256);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances by run-cycle index; results derived from the fault map at completion
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase = 0;
      mK     = 0;
      mErr   = 0;
      mFirst = 0;
    end else if (mPhase == 1) begin
      mK = mK + 1;
      if (mK == 769) begin
        mPhase = 2;
        mErr   = 0;
        mFirst = 0;
        for (int a = 0; a < 256; a++) begin
          if ((tbPat(a) | stuck1[a]) != tbPat(a)) begin
            if (mErr == 0) mFirst = a;
            mErr++;
          end
        end
      end
    end else if (start) begin
      mPhase = 1;
      mK     = 1;
    end
  end

  // Every-cycle comparison against the model on the falling edge
  always @(negedge clk) begin
    if (!rst_n || mPhase == 0) begin
      checkOutput("idleBusy",  32'(busy), 0);
      checkOutput("idleDone",  32'(done), 0);
      checkOutput("idlePass",  32'(pass), 0);
      checkOutput("idleErr",   32'(err_cnt), 0);
      checkOutput("idleFirst", 32'(first_err_ad), 0);
      checkOutput("idleW",     32'(ram_w), 0);
      checkOutput("idleCs",    32'(ram_cs), 0);
      checkOutput("idleAd",    32'(ram_ad), 0);
      checkOutput("idleDi",    32'(ram_di), 0);
    end else if (mPhase == 1) begin
      checkOutput("runBusy", 32'(busy), 1);
      checkOutput("runDone", 32'(done), 0);
      checkOutput("runPass", 32'(pass), 0);
      if (mK <= 512) begin
        checkOutput("wrW",  32'(ram_w), 32'((mK - 1) % 2 == 0));
        checkOutput("wrCs", 32'(ram_cs), 32'((mK - 1) % 2 == 0));
        checkOutput("wrAd", 32'(ram_ad), 32'((mK - 1) / 2));
        checkOutput("wrDi", 32'(ram_di), 32'(tbPat((mK - 1) / 2)));
      end else begin
        checkOutput("rdW",  32'(ram_w), 0);
        checkOutput("rdCs", 32'(ram_cs), 1);
        checkOutput("rdAd", 32'(ram_ad), 32'(mK - 513));
      end
    end else begin
      checkOutput("doneBusy",  32'(busy), 0);
      checkOutput("doneDone",  32'(done), 1);
      checkOutput("donePass",  32'(pass), 32'(mErr == 0));
      checkOutput("doneErr",   32'(err_cnt), 32'(mErr));
      checkOutput("doneFirst", 32'(first_err_ad), 32'(mFirst));
      checkOutput("doneW",     32'(ram_w), 0);
      checkOutput("doneCs",    32'(ram_cs), 0);
    end
  end

  // Pulse start, optionally add extra start pulses or a reset at given run cycles,
  // and report the run cycle on which done is first seen (-1 if reset or timeout)
  task automatic applyStimulus(input int pulseA, input int pulseB, input int resetAt,
                               output int doneCycle);
    int n;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    n = 1;
    doneCycle = -1;
    while (n < 2000) begin
      if (n == 1) checkOutput("doneDrop", 32'(done), 0);
      if (done) begin
        doneCycle = n;
        break;
      end
      if (n == resetAt) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstW",    32'(ram_w), 0);
        checkOutput("rstCs",   32'(ram_cs), 0);
        checkOutput("rstAd",   32'(ram_ad), 0);
        checkOutput("rstDi",   32'(ram_di), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        break;
      end
      start = (n == pulseA) || (n == pulseB);
      @(posedge clk); #2;
      n++;
    end
    start = 1'b0;
    if (resetAt == 0 && doneCycle < 0) checkOutput("doneTimeout", 32'(n), 769);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc;
    int nf;
    int pa;
    int pb;
    int ra;
    for (int a = 0; a < 256; a++) begin
      mem[a]    = 8'h00;
      stuck1[a] = 8'h00;
    end
    start = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("porBusy", 32'(busy), 0);
    checkOutput("porDone", 32'(done), 0);
    checkOutput("porAd",   32'(ram_ad), 0);
    checkOutput("porCs",   32'(ram_cs), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    checkOutput("idleAfterRelease", 32'(busy), 0);

    $display("[TB] good RAM run");
    applyStimulus(0, 0, 0, dc);
    checkOutput("goodDoneCycle", 32'(dc), 769);
    checkOutput("goodPass",  32'(pass), 1);
    checkOutput("goodErr",   32'(err_cnt), 0);
    checkOutput("goodFirst", 32'(first_err_ad), 0);
    checkOutput("mem250",    32'(mem[250]), 4);
    checkOutput("mem0",      32'(mem[0]), 10);

    $display("[TB] stuck bit at address 6");
    stuck1[6] = 8'h01;
    applyStimulus(0, 0, 0, dc);
    checkOutput("stuckDoneCycle", 32'(dc), 769);
    checkOutput("stuckErr",   32'(err_cnt), 1);
    checkOutput("stuckFirst", 32'(first_err_ad), 6);
    checkOutput("stuckPass",  32'(pass), 0);

    $display("[TB] start while busy and on the last read edge");
    applyStimulus(100, 600, 0, dc);
    checkOutput("busyDoneCycle", 32'(dc), 769);
    checkOutput("busyErr",   32'(err_cnt), 1);
    checkOutput("busyFirst", 32'(first_err_ad), 6);
    applyStimulus(768, 0, 0, dc);
    checkOutput("lastEdgeDoneCycle", 32'(dc), 769);
    @(posedge clk); #2;
    checkOutput("lastEdgeStillDone", 32'(done), 1);
    stuck1[6] = 8'h00;

    $display("[TB] reset during write phase");
    applyStimulus(0, 0, 300, dc);
    applyStimulus(0, 0, 0, dc);
    checkOutput("afterRstDoneCycle", 32'(dc), 769);
    checkOutput("afterRstPass", 32'(pass), 1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 256; a++) stuck1[a] = 8'h00;
      nf = $urandom_range(0, 3);
      for (int f = 0; f < nf; f++) begin
        stuck1[$urandom_range(0, 255)] |= 8'(1 << $urandom_range(0, 7));
      end
      pa = $urandom_range(1, 768);
      pb = $urandom_range(1, 768);
      ra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 768) : 0;
      applyStimulus(pa, pb, ra, dc);
      if (ra == 0) begin
        checkOutput("rndDoneCycle", 32'(dc), 769);
        checkOutput("rndErr", 32'(err_cnt), 32'(mErr));
      end
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
